// File: rtl/instr_sequencer_pkg.sv
// Shared compute-unit ISA definitions: opcodes, instruction field positions
// and the sequencer state encoding.
package compute_isa_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int TGT_MSB    = 11;
  localparam int TGT_LSB    = 8;
  localparam int SRC0_MSB   = 7;
  localparam int SRC0_LSB   = 4;
  localparam int SRC1_MSB   = 3;
  localparam int SRC1_LSB   = 0;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction issue handshake between the sequencer (master) and the
// compute unit (slave).
interface instr_sequencer_if;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr_out, output instr_valid, input instr_ready);
  modport slave  (input instr_out, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_sequencer_mem.sv
// Program store: DEPTH x 16 words, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module instr_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loads a byte-stream program into local memory and
// issues it word by word. Define INSTR_SEQ_LOOP_EN to make RUN wrap to pc=0.
module instr_sequencer
  import compute_isa_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 mode_load,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  input  logic                 start,
  instr_sequencer_if.master    instr_bus,
  output logic [AW-1:0]        pc,
  output logic [AW:0]          prog_len,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam logic [AW:0] FULL_LEN = (AW + 1)'(DEPTH);

  seq_state_t  state, state_next;
  logic [AW-1:0] pc_next;
  logic [AW:0]   len_next;
  logic          ovf_next;
  logic          phase, phase_next;
  logic [7:0]    hold, hold_next;
  logic          mem_we;
  logic [15:0]   mem_rdata;
  logic          halt_at_pc;
  logic          last_word;

  instr_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_len[AW-1:0]),
    .wdata ({hold, byte_in}),
    .raddr (pc),
    .rdata (mem_rdata)
  );

  assign halt_at_pc = (opcode_of(mem_rdata) == OP_HALT);
  assign last_word  = ({1'b0, pc} == (prog_len - (AW + 1)'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= '0;
      prog_len <= '0;
      overflow <= 1'b0;
      phase    <= 1'b0;
      hold     <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      prog_len <= len_next;
      overflow <= ovf_next;
      phase    <= phase_next;
      hold     <= hold_next;
    end
  end

  // With ena low every *_next equals its register, so the whole block freezes.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    len_next   = prog_len;
    ovf_next   = overflow;
    phase_next = phase;
    hold_next  = hold;
    mem_we     = 1'b0;

    if (ena) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (mode_load) begin
            state_next = ST_LOAD;
            len_next   = '0;
            ovf_next   = 1'b0;
            phase_next = 1'b0;
          end else if (start) begin
            if (prog_len != '0) begin
              state_next = ST_RUN;
              pc_next    = '0;
            end else begin
              state_next = ST_DONE;
            end
          end
        end

        ST_LOAD: begin
          if (!mode_load) begin
            state_next = ST_IDLE;
            phase_next = 1'b0;
          end else if (byte_valid) begin
            if (!phase) begin
              hold_next  = byte_in;
              phase_next = 1'b1;
            end else begin
              phase_next = 1'b0;
              if (prog_len < FULL_LEN) begin
                mem_we   = 1'b1;
                len_next = prog_len + (AW + 1)'(1);
              end else begin
                ovf_next = 1'b1;
              end
            end
          end
        end

        ST_RUN: begin
          // A HALT word is never offered, so it cannot be consumed by a transfer.
          if (mode_load) begin
            state_next = ST_IDLE;
          end else if (halt_at_pc) begin
            state_next = ST_DONE;
          end else if (instr_bus.instr_ready) begin
            if (last_word) begin
`ifdef INSTR_SEQ_LOOP_EN
              pc_next    = '0;
`else
              state_next = ST_DONE;
`endif
            end else begin
              pc_next = pc + AW'(1);
            end
          end
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign instr_bus.instr_out   = (state == ST_RUN) ? mem_rdata : 16'h0000;
  assign instr_bus.instr_valid = ena && (state == ST_RUN) && !halt_at_pc;
  assign busy = (state == ST_LOAD) || (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; covers load, run,
// back-pressure, HALT, overflow, odd byte count, ena, reset and loop mode.
module tb_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          mode_load;
  logic          byte_valid;
  logic [7:0]    byte_in;
  logic          start;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_len;
  logic          busy;
  logic          done;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] prog_q[$];

  instr_sequencer_if bus ();

  instr_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .mode_load  (mode_load),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .start      (start),
    .instr_bus  (bus.master),
    .pc         (pc),
    .prog_len   (prog_len),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_queue();
    mode_load = 1'b1;
    step();
    foreach (prog_q[i]) begin
      byte_valid = 1'b1;
      byte_in    = prog_q[i];
      step();
    end
    byte_valid = 1'b0;
    mode_load  = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", bus.instr_valid); end
    total++; if (bus.instr_out !== 16'h0000) begin bad++; $display("[TB] FAIL reset_instr got=%h want=0000", bus.instr_out); end
    total++; if (pc !== 4'd0) begin bad++; $display("[TB] FAIL reset_pc got=%0d want=0", pc); end
    total++; if (prog_len !== 5'd0) begin bad++; $display("[TB] FAIL reset_len got=%0d want=0", prog_len); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%0b want=0", overflow); end
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (done !== 1'b1 || bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL empty_start done=%0b valid=%0b want 1/0", done, bus.instr_valid); end
  endtask

  task automatic test_load_run();
    prog_q = '{8'h12, 8'h05, 8'h23, 8'h01};
    load_queue();
    total++; if (prog_len !== 5'd2) begin bad++; $display("[TB] FAIL basic_len got=%0d want=2", prog_len); end
    start = 1'b1; bus.instr_ready = 1'b1;
    step();
    start = 1'b0;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h1205) begin bad++; $display("[TB] FAIL basic_w0 got=%h v=%0b want=1205 v=1", bus.instr_out, bus.instr_valid); end
    step();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h2301) begin bad++; $display("[TB] FAIL basic_w1 got=%h v=%0b want=2301 v=1", bus.instr_out, bus.instr_valid); end
    step();
    total++; if (done !== 1'b1 || pc !== 4'd1 || bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_done done=%0b pc=%0d valid=%0b want 1/1/0", done, pc, bus.instr_valid); end
  endtask

  task automatic test_backpressure();
    bus.instr_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h1205 || pc !== 4'd0) begin bad++; $display("[TB] FAIL stall_%0d got=%h v=%0b pc=%0d want=1205 v=1 pc=0", i, bus.instr_out, bus.instr_valid, pc); end
      step();
    end
    bus.instr_ready = 1'b1;
    total++; if (bus.instr_out !== 16'h1205) begin bad++; $display("[TB] FAIL stall_resume0 got=%h want=1205", bus.instr_out); end
    step();
    total++; if (bus.instr_out !== 16'h2301 || pc !== 4'd1) begin bad++; $display("[TB] FAIL stall_resume1 got=%h pc=%0d want=2301 pc=1", bus.instr_out, pc); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL stall_done got=%0b want=1", done); end
  endtask

  task automatic test_halt();
    prog_q = '{8'h11, 8'h01, 8'hF0, 8'h00, 8'h22, 8'h12};
    load_queue();
    bus.instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h1101) begin bad++; $display("[TB] FAIL halt_w0 got=%h v=%0b want=1101 v=1", bus.instr_out, bus.instr_valid); end
    step();
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_presented valid=%0b want=0", bus.instr_valid); end
    step();
    total++; if (done !== 1'b1 || pc !== 4'd1 || bus.instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_done done=%0b pc=%0d valid=%0b want 1/1/0", done, pc, bus.instr_valid); end
  endtask

  task automatic test_overflow();
    logic [15:0] w;
    prog_q = {};
    for (int i = 0; i < 17; i++) begin
      w = 16'h1000 + 16'(i);
      prog_q.push_back(w[15:8]);
      prog_q.push_back(w[7:0]);
    end
    load_queue();
    total++; if (prog_len !== 5'd16 || overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flags len=%0d ovf=%0b want 16/1", prog_len, overflow); end
    bus.instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.instr_out !== 16'h1000 + 16'(i) || pc !== 4'(i)) begin bad++; $display("[TB] FAIL ovf_word%0d got=%h pc=%0d want=%h", i, bus.instr_out, pc, 16'h1000 + 16'(i)); end
      step();
    end
    total++; if (done !== 1'b1 || pc !== 4'd15) begin bad++; $display("[TB] FAIL ovf_done done=%0b pc=%0d want 1/15", done, pc); end
  endtask

  task automatic test_odd_bytes();
    prog_q = '{8'hAA, 8'hBB, 8'hCC};
    load_queue();
    total++; if (prog_len !== 5'd1 || overflow !== 1'b0) begin bad++; $display("[TB] FAIL odd_len len=%0d ovf=%0b want 1/0", prog_len, overflow); end
    bus.instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (bus.instr_out !== 16'hAABB) begin bad++; $display("[TB] FAIL odd_w0 got=%h want=aabb", bus.instr_out); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL odd_done got=%0b want=1", done); end
    bus.instr_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1 || pc !== 4'd0 || bus.instr_out !== 16'hAABB) begin bad++; $display("[TB] FAIL odd_rerun busy=%0b pc=%0d got=%h want 1/0/aabb", busy, pc, bus.instr_out); end
    bus.instr_ready = 1'b1;
    step();
  endtask

  task automatic test_ena();
    prog_q = '{8'h12, 8'h05, 8'h23, 8'h01};
    load_queue();
    bus.instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    ena = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++; if (bus.instr_valid !== 1'b0 || pc !== 4'd0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL ena_freeze%0d valid=%0b pc=%0d busy=%0b want 0/0/1", i, bus.instr_valid, pc, busy); end
      step();
    end
    ena = 1'b1;
    #1;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h1205) begin bad++; $display("[TB] FAIL ena_resume got=%h v=%0b want=1205 v=1", bus.instr_out, bus.instr_valid); end
    step();
    total++; if (pc !== 4'd1 || bus.instr_out !== 16'h2301) begin bad++; $display("[TB] FAIL ena_next pc=%0d got=%h want 1/2301", pc, bus.instr_out); end
    step();
  endtask

  task automatic test_back_to_back();
    bus.instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef INSTR_SEQ_LOOP_EN
    for (int i = 0; i < 6; i++) begin
      total++; if (bus.instr_out !== ((i % 2) ? 16'h2301 : 16'h1205) || done !== 1'b0) begin bad++; $display("[TB] FAIL loop_%0d got=%h done=%0b", i, bus.instr_out, done); end
      step();
    end
    mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || prog_len !== 5'd2) begin bad++; $display("[TB] FAIL loop_abort busy=%0b done=%0b len=%0d want 0/0/2", busy, done, prog_len); end
`else
    total++; if (bus.instr_out !== 16'h1205) begin bad++; $display("[TB] FAIL b2b_w0 got=%h want=1205", bus.instr_out); end
    step();
    total++; if (bus.instr_out !== 16'h2301) begin bad++; $display("[TB] FAIL b2b_w1 got=%h want=2301", bus.instr_out); end
    step();
    total++; if (done !== 1'b1 || pc !== 4'd1) begin bad++; $display("[TB] FAIL b2b_done done=%0b pc=%0d want 1/1", done, pc); end
`endif
  endtask

  task automatic test_reset_mid_run();
    bus.instr_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rstrun_pre busy=%0b want=1", busy); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || prog_len !== 5'd0 || bus.instr_valid !== 1'b0 || pc !== 4'd0) begin bad++; $display("[TB] FAIL rstrun busy=%0b done=%0b len=%0d valid=%0b pc=%0d want all 0", busy, done, prog_len, bus.instr_valid, pc); end
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b1; mode_load = 1'b0; byte_valid = 1'b0;
    byte_in = 8'h00; start = 1'b0; bus.instr_ready = 1'b0;
    test_reset();
    test_load_run();
    test_backpressure();
    test_halt();
    test_overflow();
    test_odd_bytes();
    test_ena();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
